// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width of the byte-lane offset inside a word.
  localparam int unsigned LaneW = 2;
  // Width of the error flag carried with a response.
  localparam int unsigned ErrW  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StLd,
    StStWr,
    StRmwRd,
    StRmwWr,
    StResp
  } lsu_state_t;

  // Loads accept all five RV32I widths; stores only B/H/W.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words a word-aligned one.
  function automatic logic misaligned(input logic [2:0] f3, input logic [LaneW-1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract/extend and store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0]      ld_word_i,
  input  logic [LaneW-1:0] off_i,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      old_word_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      ld_data_o,
  output logic [31:0]      st_word_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Pick the addressed lane and extend it to 32 bits.
  always_comb begin
    ld_byte = ld_word_i[{off_i, 3'b000} +: 8];
    ld_half = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h000000, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0000, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

  // Overlay the store lane onto the word read back from memory.
  always_comb begin
    st_word_o = old_word_i;
    case (funct3_i)
      F3_B: st_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (off_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else          st_word_o[15:0]  = wdata_i[15:0];
      end
      default: st_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core execute stage and a word-addressed data
// memory (combinational read, write on posedge). Sub-word stores are done as
// read-modify-write. Optional performance counters: define LSU_PERF_CNT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0] ld_cnt,
  output logic [31:0] st_cnt,
  output logic [31:0] err_cnt
`endif
);

  lsu_state_t       state_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      word_q;
  logic [ErrW-1:0]  err_q;

  logic             out_of_range;
  logic             req_err;
  logic [31:0]      ld_data;
  logic [31:0]      st_word;

  assign out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
  assign req_err      = ~funct3_legal(req_we, req_funct3) |
                        misaligned(req_funct3, req_addr[1:0]) | out_of_range;

  lsu_align u_align (
    .ld_word_i  (word_q),
    .off_i      (addr_q[1:0]),
    .funct3_i   (f3_q),
    .old_word_i (word_q),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  // Request latches and FSM; errors are decided at accept and skip memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      err_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            if (req_err)                 state_q <= StResp;
            else if (!req_we)            state_q <= StLd;
            else if (req_funct3 == F3_W) state_q <= StStWr;
            else                         state_q <= StRmwRd;
          end
        end
        StLd: begin
          word_q  <= mem_rd;
          state_q <= StResp;
        end
        StStWr:  state_q <= StResp;
        StRmwRd: begin
          word_q  <= mem_rd;
          state_q <= StRmwWr;
        end
        StRmwWr: state_q <= StResp;
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);

  // Memory and response outputs decoded from the registered state.
  always_comb begin
    mem_a      = 32'h0;
    mem_we     = 1'b0;
    mem_wd     = 32'h0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    if (state_q != StIdle) mem_a = {addr_q[31:2], 2'b00};
    case (state_q)
      StStWr: begin
        mem_we = 1'b1;
        mem_wd = wdata_q;
      end
      StRmwWr: begin
        mem_we = 1'b1;
        mem_wd = st_word;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_q[0];
        if (!err_q[0] && !we_q) resp_rdata = ld_data;
      end
      default: ;
    endcase
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] ld_cnt_q, st_cnt_q, err_cnt_q;

  // Count completed requests by class; errored requests only count as errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt_q  <= 32'h0;
      st_cnt_q  <= 32'h0;
      err_cnt_q <= 32'h0;
    end else if (state_q == StResp) begin
      if (err_q[0])  err_cnt_q <= err_cnt_q + 32'd1;
      else if (we_q) st_cnt_q  <= st_cnt_q + 32'd1;
      else           ld_cnt_q  <= ld_cnt_q + 32'd1;
    end
  end

  assign ld_cnt  = ld_cnt_q;
  assign st_cnt  = st_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory model plus a transaction-level
// reference model checked every cycle, and literal expectations for key cases.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] ld_cnt, st_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
`ifdef LSU_PERF_CNT_EN
    ,
    .ld_cnt     (ld_cnt),
    .st_cnt     (st_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  // Data memory: combinational read, posedge write.
  logic [31:0] mem [0:1023];
  logic        preload = 1'b1;
  assign mem_rd = mem[mem_a[11:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[64] <= 32'h8899AABB;
    end else if (mem_we) begin
      mem[mem_a[11:2]] <= mem_wd;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state: one outstanding transaction, described by the
  // cycles at which its write and response must appear.
  logic [31:0] ref_mem [0:1023];
  int          resp_cyc = -1;
  int          we_cyc = -1;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_wd = 32'h0;
  logic        m_err = 1'b0;
  logic [9:0]  m_widx = 10'h0;

  logic        ready_exp, rv_exp, we_exp, legal;
  logic [31:0] w, mask, v, lane;
  int unsigned sz, off, idx;

  // Captures for the literal checks.
  int          acc_cyc = 0;
  int          rsp_cyc = 0;
  logic [31:0] rsp_rdata = 32'h0;
  logic        rsp_err = 1'b0;
  logic        got_resp = 1'b0;

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      ref_mem[64] = 32'h8899AABB;
    end
    if (!rst) begin
      resp_cyc = -1;
      we_cyc   = -1;
    end else begin
      ready_exp = (cyc > resp_cyc);
      rv_exp    = (cyc == resp_cyc);
      we_exp    = (cyc == we_cyc);
      check("req_ready",  32'(req_ready),  32'(ready_exp));
      check("resp_valid", 32'(resp_valid), 32'(rv_exp));
      check("resp_err",   32'(resp_err),   rv_exp ? 32'(m_err) : 32'h0);
      check("resp_rdata", resp_rdata,      rv_exp ? m_rdata : 32'h0);
      check("mem_we",     32'(mem_we),     32'(we_exp));
      check("mem_wd",     mem_wd,          we_exp ? m_wd : 32'h0);
      check("mem_a",      mem_a,           ready_exp ? 32'h0 : (m_addr & 32'hFFFF_FFFC));
      if (we_exp) ref_mem[m_widx] = m_wd;
      if (resp_valid) begin
        rsp_cyc   = cyc;
        rsp_rdata = resp_rdata;
        rsp_err   = resp_err;
        got_resp  = 1'b1;
      end
      if (req_valid && ready_exp) begin
        acc_cyc = cyc;
        idx     = req_addr >> 2;
        off     = 32'(req_addr[1:0]);
        case (req_funct3[1:0])
          2'b00:   sz = 1;
          2'b01:   sz = 2;
          default: sz = 4;
        endcase
        if (req_we) legal = (req_funct3 <= 3'd2);
        else        legal = (req_funct3 <= 3'd2) || (req_funct3 == 3'd4) || (req_funct3 == 3'd5);
        m_err   = !legal || ((off % sz) != 0) || (idx >= 1024);
        m_addr  = req_addr;
        m_rdata = 32'h0;
        m_widx  = idx[9:0];
        mask    = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        if (m_err) begin
          resp_cyc = cyc + 1;
        end else if (!req_we) begin
          w = ref_mem[idx[9:0]];
          v = (w >> (8 * off)) & mask;
          // Signed narrow load: a value above half the lane range is negative.
          if (!req_funct3[2] && sz < 4 && v > (mask >> 1)) v = v | ~mask;
          m_rdata  = v;
          resp_cyc = cyc + 2;
        end else if (sz == 4) begin
          m_wd     = req_wdata;
          we_cyc   = cyc + 1;
          resp_cyc = cyc + 2;
        end else begin
          w        = ref_mem[idx[9:0]];
          lane     = mask << (8 * off);
          m_wd     = (w & ~lane) | ((req_wdata & mask) << (8 * off));
          we_cyc   = cyc + 2;
          resp_cyc = cyc + 3;
        end
      end
    end
  end

  // One request: wait for acceptance, then for its response (both bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    logic accepted;
    int   n;
    accepted   = 1'b0;
    got_resp   = 1'b0;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!accepted && n < 20) begin
      @(negedge clk);
      if (req_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!accepted) check("accept_timeout", 32'h0, 32'h1);
    n = 0;
    while (!got_resp && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!got_resp) check("resp_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  int acc [0:2];
  int na, nw;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    check("rst_req_ready",  32'(req_ready),  32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata,      32'h0);
    check("rst_resp_err",   32'(resp_err),   32'h0);
    check("rst_mem_we",     32'(mem_we),     32'h0);
    check("rst_mem_a",      mem_a,           32'h0);
    check("rst_mem_wd",     mem_wd,          32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Loads
    do_req(1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_lat",   32'(rsp_cyc - acc_cyc), 32'd2);
    check("lw_rdata", rsp_rdata, 32'h8899AABB);
    check("lw_err",   32'(rsp_err), 32'h0);
    do_req(1'b0, 3'b000, 32'h101, 32'h0);
    check("lb_rdata", rsp_rdata, 32'hFFFFFFAA);
    do_req(1'b0, 3'b100, 32'h101, 32'h0);
    check("lbu_rdata", rsp_rdata, 32'h000000AA);
    do_req(1'b0, 3'b001, 32'h102, 32'h0);
    check("lh_rdata", rsp_rdata, 32'hFFFF8899);
    do_req(1'b0, 3'b101, 32'h102, 32'h0);
    check("lhu_rdata", rsp_rdata, 32'h00008899);

    // Sub-word stores (read-modify-write)
    do_req(1'b1, 3'b000, 32'h102, 32'h0000_0012);
    check("sb_lat",  32'(rsp_cyc - acc_cyc), 32'd3);
    check("sb_word", mem[64], 32'h8812AABB);
    do_req(1'b1, 3'b001, 32'h100, 32'h0000_BEEF);
    check("sh_word", mem[64], 32'h8812BEEF);
    do_req(1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_after_st", rsp_rdata, 32'h8812BEEF);

    // Errors
    do_req(1'b0, 3'b010, 32'h102, 32'h0);
    check("mis_lat", 32'(rsp_cyc - acc_cyc), 32'd1);
    check("mis_err", 32'(rsp_err), 32'h1);
    do_req(1'b1, 3'b010, 32'h1000, 32'hDEAD_BEEF);
    check("oor_err", 32'(rsp_err), 32'h1);
    do_req(1'b1, 3'b011, 32'h100, 32'h0000_0077);
    check("f3_err",  32'(rsp_err), 32'h1);
    check("err_word", mem[64], 32'h8812BEEF);

    // Reset during the read phase of an SB
    got_resp   = 1'b0;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h100;
    req_wdata  = 32'h55;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mid_we",    32'(mem_we),    32'h0);
    check("rst_mid_ready", 32'(req_ready), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_word", mem[64], 32'h8812BEEF);
    check("rst_mid_resp", 32'(got_resp), 32'h0);
    check("rst_mid_rdy2", 32'(req_ready), 32'h1);

    // Three back-to-back LWs with req_valid held
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    req_valid  = 1'b1;
    na = 0;
    nw = 0;
    while (na < 3 && nw < 30) begin
      @(negedge clk);
      if (req_ready) begin
        acc[na] = cyc;
        na++;
      end
      nw++;
      if (na < 3) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("held_accepts", 32'(na), 32'd3);
    if (na == 3) begin
      check("held_gap1", 32'(acc[1] - acc[0]), 32'd3);
      check("held_gap2", 32'(acc[2] - acc[1]), 32'd3);
    end
    repeat (4) @(posedge clk);
    #1;
`ifdef LSU_PERF_CNT_EN
    check("ld_cnt",  ld_cnt,  32'd3);
    check("st_cnt",  st_cnt,  32'd0);
    check("err_cnt", err_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
